// File: rtl/i2s_pkg.sv
// Shared I2S types: receiver FSM states and channel encoding on lrclk.
package i2s_pkg;

  typedef enum logic [1:0] {ALIGN, SHIFT, HOLD} i2s_rx_state_t;

  localparam logic I2S_LEFT  = 1'b0;
  localparam logic I2S_RIGHT = 1'b1;

endpackage

// File: rtl/i2s_rx_sync_edge.sv
// Multi-stage synchroniser for an asynchronous pin with a rising-edge strobe.
module sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise
);

  logic [STAGES-1:0] chain;
  logic              prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= '0;
      prev  <= 1'b0;
    end else begin
      chain <= {chain[STAGES-2:0], din};
      prev  <= chain[STAGES-1];
    end
  end

  assign rise = chain[STAGES-1] & ~prev;

endmodule

// File: rtl/i2s_rx.sv
// I2S ADC receiver: oversamples bclk/lrclk/adcdat on clk and assembles
// MSB-aligned left/right words, publishing them together once per frame.
module i2s_rx
  import i2s_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  bclk,
  input  logic                  lrclk,
  input  logic                  adcdat,
  output logic [DATA_WIDTH-1:0] left_out,
  output logic [DATA_WIDTH-1:0] right_out,
  output logic                  sample_valid,
  output logic                  frame_err,
  output logic                  aligned
);

  localparam int CW = $clog2(DATA_WIDTH + 1);

  logic                   bclk_rise;
  logic [SYNC_STAGES-1:0] lr_chain, dat_chain;
  logic                   lr_s, dat_s;

  sync_edge #(.STAGES(SYNC_STAGES)) u_bclk_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (bclk),
    .rise (bclk_rise)
  );

  // Same depth as the bclk chain so lrclk/adcdat line up with bclk_rise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lr_chain  <= '0;
      dat_chain <= '0;
    end else begin
      lr_chain  <= {lr_chain[SYNC_STAGES-2:0], lrclk};
      dat_chain <= {dat_chain[SYNC_STAGES-2:0], adcdat};
    end
  end

  assign lr_s  = lr_chain[SYNC_STAGES-1];
  assign dat_s = dat_chain[SYNC_STAGES-1];

  i2s_rx_state_t          state, state_nx;
  logic [CW-1:0]          bit_cnt, bit_cnt_nx;
  logic                   chan, chan_nx;
  logic                   lr_prev, lr_prev_nx;
  logic                   lr_seen, lr_seen_nx;
  logic                   left_ok, left_ok_nx;
  logic [DATA_WIDTH-1:0]  shreg, shreg_nx, hold_l, hold_l_nx;
  logic [DATA_WIDTH-1:0]  left_nx, right_nx;
  logic                   valid_nx, err_nx, aligned_nx;
  logic                   boundary, last_bit;
  logic [DATA_WIDTH-1:0]  shifted;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ALIGN;
      bit_cnt      <= '0;
      chan         <= I2S_LEFT;
      lr_prev      <= 1'b0;
      lr_seen      <= 1'b0;
      left_ok      <= 1'b0;
      shreg        <= '0;
      hold_l       <= '0;
      left_out     <= '0;
      right_out    <= '0;
      sample_valid <= 1'b0;
      frame_err    <= 1'b0;
      aligned      <= 1'b0;
    end else begin
      state        <= state_nx;
      bit_cnt      <= bit_cnt_nx;
      chan         <= chan_nx;
      lr_prev      <= lr_prev_nx;
      lr_seen      <= lr_seen_nx;
      left_ok      <= left_ok_nx;
      shreg        <= shreg_nx;
      hold_l       <= hold_l_nx;
      left_out     <= left_nx;
      right_out    <= right_nx;
      sample_valid <= valid_nx;
      frame_err    <= err_nx;
      aligned      <= aligned_nx;
    end
  end

  // lr_seen keeps the very first sampled lrclk from counting as an edge.
  assign boundary = lr_seen && (lr_s != lr_prev);
  assign last_bit = (bit_cnt == CW'(DATA_WIDTH - 1));
  assign shifted  = {shreg[DATA_WIDTH-2:0], dat_s};

  always_comb begin
    state_nx   = state;
    bit_cnt_nx = bit_cnt;
    chan_nx    = chan;
    lr_prev_nx = lr_prev;
    lr_seen_nx = lr_seen;
    left_ok_nx = left_ok;
    shreg_nx   = shreg;
    hold_l_nx  = hold_l;
    left_nx    = left_out;
    right_nx   = right_out;
    valid_nx   = 1'b0;
    err_nx     = 1'b0;
    aligned_nx = aligned;
    if (bclk_rise) begin
      lr_prev_nx = lr_s;
      lr_seen_nx = 1'b1;
      case (state)
        ALIGN: begin
          if (boundary) begin
            state_nx   = SHIFT;
            bit_cnt_nx = '0;
            chan_nx    = lr_s;
            aligned_nx = 1'b1;
          end
        end
        SHIFT: begin
          // A boundary carrying the final bit is the LSB of an exact-width slot.
          if (!boundary || last_bit) begin
            shreg_nx   = shifted;
            bit_cnt_nx = bit_cnt + CW'(1);
            if (last_bit) begin
              state_nx = HOLD;
              if (chan == I2S_LEFT) begin
                hold_l_nx  = shifted;
                left_ok_nx = 1'b1;
              end else if (left_ok) begin
                left_nx    = hold_l;
                right_nx   = shifted;
                valid_nx   = 1'b1;
                left_ok_nx = 1'b0;
              end
            end
          end else begin
            err_nx     = 1'b1;
            left_ok_nx = 1'b0;
          end
          if (boundary) begin
            state_nx   = SHIFT;
            bit_cnt_nx = '0;
            chan_nx    = lr_s;
          end
        end
        HOLD: begin
          if (boundary) begin
            state_nx   = SHIFT;
            bit_cnt_nx = '0;
            chan_nx    = lr_s;
          end
        end
        default: state_nx = ALIGN;
      endcase
    end
  end

endmodule

// File: tb/tb_i2s_rx.sv
// Bench for i2s_rx: codec-style BFM, slot-level reference model, scoreboard monitor.
module tb_i2s_rx;

  localparam int W    = 16;
  localparam int SYNC = 2;

  logic         clk, rst_n, bclk, lrclk, adcdat;
  logic [W-1:0] left_out, right_out;
  logic         sample_valid, frame_err, aligned;

  i2s_rx #(.DATA_WIDTH(W), .SYNC_STAGES(SYNC)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bclk        (bclk),
    .lrclk       (lrclk),
    .adcdat      (adcdat),
    .left_out    (left_out),
    .right_out   (right_out),
    .sample_valid(sample_valid),
    .frame_err   (frame_err),
    .aligned     (aligned)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  typedef struct {
    bit          err;
    logic [15:0] l;
    logic [15:0] r;
    int          idx;
  } ev_t;

  ev_t   exp_q[$];
  logic  bit_q[$];
  logic  chan_q[$];
  int    rise_cyc[$];
  logic  slot_chan[$];
  int    slot_len[$];
  int    slot_start[$];
  logic [31:0] slot_val[$];

  int tests = 0, failed = 0;
  int cyc = 0;
  int last_valid_cyc = -1;
  int period_exp = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      failed++;
      $display("FAIL %s actual=%h expected=%h", name, act, expv);
    end
  endtask

  // Monitor: every pulse pops one expected event.
  always @(negedge clk) begin
    if (rst_n && (sample_valid || frame_err)) begin
      tests++;
      if (sample_valid && frame_err) begin
        failed++;
        $display("FAIL pulse_overlap actual=valid+err required=one_pulse");
      end else if (exp_q.size() == 0) begin
        failed++;
        $display("FAIL unexpected_pulse actual=valid:%0b err:%0b required=none", sample_valid, frame_err);
      end else begin
        ev_t e;
        e = exp_q.pop_front();
        if (e.err != frame_err ||
            (sample_valid && (left_out !== e.l || right_out !== e.r))) begin
          failed++;
          $display("FAIL scoreboard actual=err:%0b L:%h R:%h required=err:%0b L:%h R:%h",
                   frame_err, left_out, right_out, e.err, e.l, e.r);
        end
        if (sample_valid) begin
          int lat;
          lat = cyc - rise_cyc[e.idx];
          tests++;
          if (lat < SYNC + 1 || lat > SYNC + 2) begin
            failed++;
            $display("FAIL latency actual=%0d required=%0d..%0d", lat, SYNC + 1, SYNC + 2);
          end
          if (period_exp > 0 && last_valid_cyc >= 0) begin
            int d;
            d = cyc - last_valid_cyc;
            tests++;
            if (d < period_exp - 1 || d > period_exp + 1) begin
              failed++;
              $display("FAIL pulse_spacing actual=%0d required=%0d+/-1", d, period_exp);
            end
          end
          last_valid_cyc = cyc;
        end
      end
    end
  end

  task automatic clear_stream();
    bit_q.delete(); chan_q.delete(); rise_cyc.delete();
    slot_chan.delete(); slot_len.delete(); slot_start.delete(); slot_val.delete();
    last_valid_cyc = -1;
    period_exp = 0;
  endtask

  task automatic add_slot(input logic ch, input int len, input logic [31:0] val);
    slot_chan.push_back(ch);
    slot_len.push_back(len);
    slot_start.push_back(bit_q.size());
    slot_val.push_back(val);
    for (int i = len - 1; i >= 0; i--) begin
      bit_q.push_back(val[i]);
      chan_q.push_back(ch);
    end
  endtask

  // Reference: every slot after the first lrclk edge is a word; the final
  // slot of a stream is a trailer whose bits only close the previous word.
  task automatic build_expect(input int first, input int last_excl);
    bit          left_ok;
    logic [15:0] hold;
    left_ok = 0;
    hold = '0;
    for (int s = first + 1; s < last_excl; s++) begin
      logic [15:0] word;
      ev_t e;
      word = 16'(slot_val[s] >> (slot_len[s] - W));
      if (slot_len[s] < W) begin
        e.err = 1; e.l = '0; e.r = '0; e.idx = 0;
        exp_q.push_back(e);
        left_ok = 0;
      end else if (slot_chan[s] == 1'b0) begin
        hold = word;
        left_ok = 1;
      end else if (left_ok) begin
        e.err = 0; e.l = hold; e.r = word; e.idx = slot_start[s] + W - 1;
        exp_q.push_back(e);
        left_ok = 0;
      end
    end
  endtask

  task automatic do_reset();
    bclk = 1'b0; lrclk = 1'b0; adcdat = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #3;
  endtask

  // lrclk leads data by one bit; everything changes on the bclk fall.
  task automatic play(input int reset_idx);
    int n;
    n = bit_q.size();
    for (int k = 0; k < n; k++) begin
      bclk   = 1'b0;
      adcdat = bit_q[k];
      lrclk  = (k + 1 < n) ? chan_q[k + 1] : chan_q[k];
      if (k == reset_idx) begin
        #40;
        rst_n = 1'b0;
        #1;
        check("rst_left", 32'(left_out), 0);
        check("rst_right", 32'(right_out), 0);
        check("rst_aligned", 32'(aligned), 0);
        repeat (3) @(posedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #3;
      end
      #160;
      bclk = 1'b1;
      rise_cyc.push_back(cyc);
      #160;
    end
  endtask

  task automatic drain(input string name);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 3000) begin
      @(posedge clk);
      t++;
    end
    repeat (200) @(posedge clk);
    check(name, 32'(exp_q.size()), 0);
    exp_q.delete();
  endtask

  initial begin
    rst_n = 1'b0; bclk = 1'b0; lrclk = 1'b0; adcdat = 1'b0;
    #25;
    check("reset_left", 32'(left_out), 0);
    check("reset_right", 32'(right_out), 0);
    check("reset_valid", 32'(sample_valid), 0);
    check("reset_err", 32'(frame_err), 0);
    check("reset_aligned", 32'(aligned), 0);

    // 1: 16-bit slots, first frame lost to alignment
    clear_stream();
    for (int f = 0; f < 3; f++) begin
      add_slot(1'b0, 16, 32'hA5C3);
      add_slot(1'b1, 16, 32'h1234);
    end
    add_slot(1'b0, 2, 32'h0);
    build_expect(0, slot_chan.size() - 1);
    check("t1_expected_pulses", 32'(exp_q.size()), 2);
    do_reset();
    play(-1);
    drain("t1_drain");
    check("t1_left", 32'(left_out), 32'hA5C3);
    check("t1_right", 32'(right_out), 32'h1234);
    check("t1_aligned", 32'(aligned), 1);

    // 2: 32-bit slots keep the top 16 bits
    clear_stream();
    for (int f = 0; f < 3; f++) begin
      add_slot(1'b0, 32, 32'h8001_FFFF);
      add_slot(1'b1, 32, 32'h7FFF_0000);
    end
    add_slot(1'b0, 2, 32'h0);
    build_expect(0, slot_chan.size() - 1);
    do_reset();
    play(-1);
    drain("t2_drain");
    check("t2_left", 32'(left_out), 32'h8001);
    check("t2_right", 32'(right_out), 32'h7FFF);

    // 3: short left slot -> frame_err, then recovery
    clear_stream();
    add_slot(1'b0, 16, 32'h1111);
    add_slot(1'b1, 16, 32'h2222);
    add_slot(1'b0, 10, 32'h3FF);
    add_slot(1'b1, 16, 32'h4444);
    add_slot(1'b0, 16, 32'h0001);
    add_slot(1'b1, 16, 32'hFFFF);
    add_slot(1'b0, 2, 32'h0);
    build_expect(0, slot_chan.size() - 1);
    do_reset();
    play(-1);
    drain("t3_drain");
    check("t3_left", 32'(left_out), 32'h0001);
    check("t3_right", 32'(right_out), 32'hFFFF);

    // 4: reset mid right word of frame 2
    clear_stream();
    for (int f = 0; f < 4; f++) begin
      add_slot(1'b0, 16, 32'h0100 + 32'(f));
      add_slot(1'b1, 16, 32'hC000 + 32'(f));
    end
    add_slot(1'b0, 2, 32'h0);
    build_expect(0, 3);
    build_expect(3, slot_chan.size() - 1);
    do_reset();
    play(slot_start[3] + 5);
    drain("t4_drain");
    check("t4_left", 32'(left_out), 32'h0103);
    check("t4_right", 32'(right_out), 32'hC003);

    // 5: start in the middle of a left slot
    clear_stream();
    add_slot(1'b0, 7, 32'h55);
    add_slot(1'b1, 16, 32'hBEEF);
    add_slot(1'b0, 16, 32'h7E57);
    add_slot(1'b1, 16, 32'h8000);
    add_slot(1'b0, 16, 32'h0F0F);
    add_slot(1'b1, 16, 32'hF0F0);
    add_slot(1'b0, 2, 32'h0);
    build_expect(0, slot_chan.size() - 1);
    do_reset();
    check("t5_aligned_before", 32'(aligned), 0);
    play(-1);
    drain("t5_drain");
    check("t5_left", 32'(left_out), 32'h0F0F);
    check("t5_aligned_after", 32'(aligned), 1);

    // 6: random frames at 16-bit and 24-bit slot widths
    for (int run = 0; run < 2; run++) begin
      int sw, nf;
      sw = (run == 0) ? 16 : 24;
      nf = (run == 0) ? 50 : 30;
      clear_stream();
      for (int f = 0; f < nf; f++) begin
        add_slot(1'b0, sw, $urandom & ((32'h1 << sw) - 1));
        add_slot(1'b1, sw, $urandom & ((32'h1 << sw) - 1));
      end
      add_slot(1'b0, 2, 32'h0);
      build_expect(0, slot_chan.size() - 1);
      period_exp = 2 * sw * 16;
      do_reset();
      play(-1);
      drain((run == 0) ? "t6_drain16" : "t6_drain24");
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #20ms;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
